// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result for the instruction in D3, commits it to a
// 32x32 register file with write-through read ports, and counts retired writebacks.
module writeback_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode_d3,
  input  logic [4:0]  rd_d3,
  input  logic        register_we_d3,
  input  logic [31:0] alu_out_d3,
  input  logic [31:0] DOut_d3,
  input  logic [31:0] immediate_value_d3,
  input  logic [31:0] reg_rs1_d3,
  input  logic [31:0] sum_d3,
  input  logic [31:0] multiply_d3,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] wb_data,
  output logic        wb_valid_q,
  output logic [4:0]  wb_rd_q,
  output logic [31:0] wb_data_q,
  output logic [31:0] instret
);

  localparam logic [5:0] OP_LOAD   = 6'h10;
  localparam logic [5:0] OP_IMM    = 6'h12;
  localparam logic [5:0] OP_MOVRS1 = 6'h13;
  localparam logic [5:0] OP_SUM    = 6'h14;
  localparam logic [5:0] OP_MUL    = 6'h15;

  logic [31:0] regs_reg [1:31];
  logic [31:0] rf_view  [32];
  logic [4:0]  rd_addr  [2];
  logic [31:0] rd_data  [2];
  logic        commit_pending;
  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic [31:0] instret_reg;
  logic [31:0] instret_next;

  always_comb begin
    wb_data = alu_out_d3;
    case (opcode_d3)
      OP_LOAD:   wb_data = DOut_d3;
      OP_IMM:    wb_data = immediate_value_d3;
      OP_MOVRS1: wb_data = reg_rs1_d3;
      OP_SUM:    wb_data = sum_d3;
      OP_MUL:    wb_data = multiply_d3;
      default:   wb_data = alu_out_d3;
    endcase
  end

  // Reset masks the commit so neither the array nor the bypass sees a dropped write.
  assign commit_pending = register_we_d3 && (rd_d3 != 5'd0) && !reset;

  always_ff @(posedge clock) begin
    for (int i = 1; i < 32; i++) begin
      if (reset) begin
        regs_reg[i] <= '0;
      end else if (commit_pending && (rd_d3 == 5'(i))) begin
        regs_reg[i] <= wb_data;
      end
    end
  end

  // Register 0 has no storage; it is hardwired to zero in the read view.
  assign rf_view[0] = '0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_view
      assign rf_view[gi] = regs_reg[gi];
    end
  endgenerate

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_data[gi] = (commit_pending && (rd_addr[gi] == rd_d3)) ? wb_data
                                                                      : rf_view[rd_addr[gi]];
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  // Forwarding copy: valid pulses per commit, rd/data hold the last committed write.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
    end else begin
      wb_valid_reg <= commit_pending;
      if (commit_pending) begin
        wb_rd_reg   <= rd_d3;
        wb_data_reg <= wb_data;
      end
    end
  end

  // Writes to r0 still retire, so the counter follows the request, not the commit.
  assign instret_next = instret_reg + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      instret_reg <= '0;
    end else if (register_we_d3) begin
      instret_reg <= instret_next;
    end
  end

  assign wb_valid_q = wb_valid_reg;
  assign wb_rd_q    = wb_rd_reg;
  assign wb_data_q  = wb_data_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: each driven writeback pushes its expected
// outcome to a scoreboard queue that is popped and checked after the clock edge.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode_d3;
  logic [4:0]  rd_d3;
  logic        register_we_d3;
  logic [31:0] alu_out_d3, DOut_d3, immediate_value_d3, reg_rs1_d3, sum_d3, multiply_d3;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [31:0] instret;

  always #5 clock = ~clock;

  writeback_regfile dut (
    .clock              (clock),
    .reset              (reset),
    .opcode_d3          (opcode_d3),
    .rd_d3              (rd_d3),
    .register_we_d3     (register_we_d3),
    .alu_out_d3         (alu_out_d3),
    .DOut_d3            (DOut_d3),
    .immediate_value_d3 (immediate_value_d3),
    .reg_rs1_d3         (reg_rs1_d3),
    .sum_d3             (sum_d3),
    .multiply_d3        (multiply_d3),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .wb_data            (wb_data),
    .wb_valid_q         (wb_valid_q),
    .wb_rd_q            (wb_rd_q),
    .wb_data_q          (wb_data_q),
    .instret            (instret)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  logic [31:0] model_rf [32];
  logic [31:0] exp_instret;
  logic [4:0]  exp_rd_q;
  logic [31:0] exp_data_q;
  logic        exp_valid_q;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Candidates are base+1..base+6 so a wrong select always shows a different value.
  function automatic logic [31:0] ref_select(input logic [5:0] op, input logic [31:0] base);
    case (op)
      6'h10:   return base + 32'd2;
      6'h12:   return base + 32'd3;
      6'h13:   return base + 32'd4;
      6'h14:   return base + 32'd5;
      6'h15:   return base + 32'd6;
      default: return base + 32'd1;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [5:0] op,
                       input logic [4:0] rd, input logic [31:0] base);
    wb_exp_t e;
    reset              = rst;
    register_we_d3     = we;
    opcode_d3          = op;
    rd_d3              = rd;
    alu_out_d3         = base + 32'd1;
    DOut_d3            = base + 32'd2;
    immediate_value_d3 = base + 32'd3;
    reg_rs1_d3         = base + 32'd4;
    sum_d3             = base + 32'd5;
    multiply_d3        = base + 32'd6;
    e.rst   = rst;
    e.we    = we;
    e.valid = we && (rd != 5'd0) && !rst;
    e.rd    = rd;
    e.data  = ref_select(op, base);
    sb_q.push_back(e);
    #1;
    check("wb_data_select", wb_data, e.data);
  endtask

  // Expected read value: model array, bypassed by a pending (non-reset) commit.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (register_we_d3 && !reset && (rd_d3 == a)) return ref_select(opcode_d3, alu_out_d3 - 32'd1);
    return model_rf[a];
  endfunction

  task automatic check_ports(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    check({tag, "_rs1"}, rs1_data, exp_read(a1));
    check({tag, "_rs2"}, rs2_data, exp_read(a2));
  endtask

  // Idle the write port before reading so the array itself is observed.
  task automatic read_array(input string tag, input logic [4:0] a);
    register_we_d3 = 1'b0;
    check_ports(tag, a, a);
  endtask

  task automatic step(input string tag);
    wb_exp_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      if (e.rst) begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        exp_instret = '0;
        exp_valid_q = 1'b0;
        exp_rd_q    = '0;
        exp_data_q  = '0;
      end else begin
        if (e.we) exp_instret = exp_instret + 32'd1;
        exp_valid_q = e.valid;
        if (e.valid) begin
          model_rf[e.rd] = e.data;
          exp_rd_q       = e.rd;
          exp_data_q     = e.data;
        end
      end
      check({tag, "_wb_valid_q"}, {31'd0, wb_valid_q}, {31'd0, exp_valid_q});
      check({tag, "_wb_rd_q"}, {27'd0, wb_rd_q}, {27'd0, exp_rd_q});
      check({tag, "_wb_data_q"}, wb_data_q, exp_data_q);
      check({tag, "_instret"}, instret, exp_instret);
      $display("[TB] %s: valid_q=%0b rd_q=%0d data_q=%h instret=%0d", tag,
               wb_valid_q, wb_rd_q, wb_data_q, instret);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    exp_instret = '0;
    exp_valid_q = 1'b0;
    exp_rd_q    = '0;
    exp_data_q  = '0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;

    drive(1'b1, 1'b0, 6'h00, 5'd0, 32'd0);
    step("reset0");
    drive(1'b1, 1'b0, 6'h00, 5'd0, 32'd0);
    step("reset1");
    read_array("reset_r5", 5'd5);

    // First commit right after reset: load result into r5.
    drive(1'b0, 1'b1, 6'h10, 5'd5, 32'hDEADBEED);
    step("load_r5");
    read_array("read_r5", 5'd5);

    // Write to r0 is discarded but still retires.
    drive(1'b0, 1'b1, 6'h15, 5'd0, 32'd1);
    check_ports("r0_pending", 5'd0, 5'd0);
    step("mul_r0");
    read_array("read_r0", 5'd0);

    // Same-cycle write-through on rs2; rs1 on a different register sees the array.
    drive(1'b0, 1'b1, 6'h12, 5'd9, 32'h00001231);
    check_ports("bypass_r9", 5'd5, 5'd9);
    step("imm_r9");
    read_array("read_r9", 5'd9);

    // Select sweep into distinct registers.
    drive(1'b0, 1'b1, 6'h13, 5'd10, 32'h10000000);
    step("movrs1_r10");
    drive(1'b0, 1'b1, 6'h14, 5'd11, 32'h20000000);
    step("sum_r11");
    drive(1'b0, 1'b1, 6'h3F, 5'd12, 32'h30000000);
    step("alu_r12");
    drive(1'b0, 1'b1, 6'h11, 5'd31, 32'h40000000);
    step("alu_r31");
    read_array("read_r10", 5'd10);
    read_array("read_r11", 5'd11);
    read_array("read_r12", 5'd12);
    check_ports("read_r31_r9", 5'd31, 5'd9);

    // Overwrite with back-to-back writes to r7; second is bypassed before its edge.
    drive(1'b0, 1'b1, 6'h14, 5'd7, 32'h00000100);
    step("sum_r7a");
    drive(1'b0, 1'b1, 6'h15, 5'd7, 32'h00000200);
    check_ports("bypass_r7", 5'd7, 5'd7);
    step("mul_r7b");
    read_array("read_r7", 5'd7);

    // No write request: valid drops, rd/data hold, instret unchanged, r8 untouched.
    drive(1'b0, 1'b0, 6'h10, 5'd8, 32'h50000000);
    check_ports("nowe_r8", 5'd8, 5'd7);
    step("idle_r8");
    read_array("read_r8", 5'd8);

    // Reset with an in-flight write to r3: bypass is suppressed, write is dropped.
    drive(1'b0, 1'b1, 6'h00, 5'd3, 32'hA5A5A5A4);
    step("alu_r3");
    read_array("read_r3", 5'd3);
    drive(1'b1, 1'b1, 6'h10, 5'd3, 32'h11110000);
    check_ports("reset_nobypass_r3", 5'd3, 5'd3);
    step("reset_drop_r3");
    read_array("reset_r3", 5'd3);
    read_array("reset_r5b", 5'd5);
    drive(1'b0, 1'b1, 6'h14, 5'd3, 32'h00000070);
    step("post_reset_r3");
    read_array("read_r3b", 5'd3);

    // Preload the counter two short of wrap, then retire twice (one to r0).
    dut.instret_reg = 32'hFFFFFFFE;
    exp_instret     = 32'hFFFFFFFE;
    drive(1'b0, 1'b1, 6'h12, 5'd4, 32'h00000900);
    step("wrap_pre");
    drive(1'b0, 1'b1, 6'h12, 5'd0, 32'h00000A00);
    step("wrap_zero");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
